bit_serializer: RTL and testbench

//   Parallel-to-serial front end for the serial sequence detector (my_fsm).

---
 rtl/bit_serializer_pkg.sv | 15 +
 rtl/bit_serializer_if.sv | 20 ++
 rtl/bit_serializer.sv | 133 +++++++++++++
 tb/tb_bit_serializer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/bit_serializer_pkg.sv
// rtl/bit_serializer_pkg.sv - shared state encoding and sizing helper for bit_serializer
package ser_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2
    } ser_state_t;

    // Width of the bit counter; floors at 1 so a degenerate WIDTH still yields a legal vector.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// rtl/bit_serializer_if.sv - parallel word valid/ready handshake feeding bit_serializer
interface bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - MSB-first parallel-to-serial front end; SERIALIZER_PARITY_EN appends an even-parity bit
module bit_serializer
    import ser_pkg::*;
#(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    bit_serializer_if.slave  up,
    output logic             out,
    output logic             out_valid,
    output logic             busy
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    ser_state_t       state_q;
    ser_state_t       state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [CW-1:0]    bit_cnt_q;
    logic             out_q;
    logic             out_valid_q;
    logic             ready;
    logic             last_bit;
    logic             accept;
`ifdef SERIALIZER_PARITY_EN
    logic             parity_q;
`endif

    assign last_bit = (bit_cnt_q == LAST_CNT);
    assign accept   = up.data_valid && ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (last_bit) begin
`ifdef SERIALIZER_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = accept ? S_SHIFT : S_IDLE;
`endif
                end
            end
            S_PARITY: begin
                state_d = accept ? S_SHIFT : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Ready depends only on state and counter so upstream never sees a valid->ready loop.
    always_comb begin
        ready = 1'b0;
        busy  = (state_q != S_IDLE);
        case (state_q)
            S_IDLE:   ready = 1'b1;
`ifdef SERIALIZER_PARITY_EN
            S_SHIFT:  ready = 1'b0;
`else
            S_SHIFT:  ready = last_bit;
`endif
            S_PARITY: ready = 1'b1;
            default:  ready = 1'b0;
        endcase
    end

    // shreg_q holds the bits still to be sent; out_q already carries the current one.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            out_q       <= IDLE_BIT;
            out_valid_q <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else if (accept) begin
            shreg_q     <= {up.data_in[WIDTH-2:0], 1'b0};
            bit_cnt_q   <= '0;
            out_q       <= up.data_in[WIDTH-1];
            out_valid_q <= 1'b1;
`ifdef SERIALIZER_PARITY_EN
            parity_q    <= ^up.data_in;
`endif
        end else begin
            case (state_q)
                S_SHIFT: begin
                    if (!last_bit) begin
                        shreg_q     <= {shreg_q[WIDTH-2:0], 1'b0};
                        bit_cnt_q   <= bit_cnt_q + 1'b1;
                        out_q       <= shreg_q[WIDTH-1];
                        out_valid_q <= 1'b1;
                    end else begin
`ifdef SERIALIZER_PARITY_EN
                        out_q       <= parity_q;
                        out_valid_q <= 1'b1;
`else
                        out_q       <= IDLE_BIT;
                        out_valid_q <= 1'b0;
`endif
                    end
                end
                default: begin
                    out_q       <= IDLE_BIT;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign up.data_ready = ready;
    assign out           = out_q;
    assign out_valid     = out_valid_q;

endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - directed self-checking bench for bit_serializer (WIDTH=8, IDLE_BIT=0)
module tb_bit_serializer;

`ifdef SERIALIZER_PARITY_EN
    localparam int NBITS = 9;
`else
    localparam int NBITS = 8;
`endif

    logic clock;
    logic reset;
    logic ser_out;
    logic ser_out_valid;
    logic ser_busy;
    int   n_cmp;
    int   n_bad;

    bit_serializer_if #(.WIDTH(8)) sif ();

    bit_serializer #(
        .WIDTH    (8),
        .IDLE_BIT (1'b0)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .up        (sif.slave),
        .out       (ser_out),
        .out_valid (ser_out_valid),
        .busy      (ser_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic test_reset();
        reset = 1'b0;
        sif.data_valid = 1'b0;
        sif.data_in = 8'h00;
        repeat (3) @(negedge clock);
        n_cmp++;
        if (ser_out_valid !== 1'b0 || ser_out !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hold: out=%b out_valid=%b required 0/0", ser_out, ser_out_valid);
        end
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            n_cmp++;
            if ({ser_out, ser_out_valid, sif.data_ready, ser_busy} !== 4'b0010) begin
                n_bad++;
                $display("FAIL idle_cycle%0d: out/valid/ready/busy=%b%b%b%b required 0010",
                         i, ser_out, ser_out_valid, sif.data_ready, ser_busy);
            end
        end
    endtask

    task automatic test_single(input logic [7:0] w, input logic par);
        logic exp_bit;
        @(negedge clock);
        sif.data_in = w;
        sif.data_valid = 1'b1;
        n_cmp++;
        if (sif.data_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL single_ready_%h: data_ready=%b required 1", w, sif.data_ready);
        end
        @(posedge clock);
        #1 sif.data_valid = 1'b0;
        for (int i = 0; i < NBITS; i++) begin
            @(negedge clock);
            exp_bit = (i < 8) ? w[7-i] : par;
            n_cmp++;
            if (ser_out !== exp_bit || ser_out_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL single_%h_bit%0d: out=%b valid=%b required %b/1",
                         w, i, ser_out, ser_out_valid, exp_bit);
            end
            n_cmp++;
            if (sif.data_ready !== (i == NBITS - 1)) begin
                n_bad++;
                $display("FAIL single_%h_ready%0d: data_ready=%b required %b",
                         w, i, sif.data_ready, (i == NBITS - 1));
            end
        end
        @(negedge clock);
        n_cmp++;
        if ({ser_out, ser_out_valid, ser_busy} !== 3'b000) begin
            n_bad++;
            $display("FAIL single_%h_after: out/valid/busy=%b%b%b required 000",
                     w, ser_out, ser_out_valid, ser_busy);
        end
    endtask

    task automatic test_back_to_back(input logic [7:0] w0, input logic p0,
                                     input logic [7:0] w1, input logic p1);
        logic exp_bit;
        int   k;
        @(negedge clock);
        sif.data_in = w0;
        sif.data_valid = 1'b1;
        @(posedge clock);
        #1 sif.data_in = w1;
        for (int i = 0; i < 2 * NBITS; i++) begin
            @(negedge clock);
            k = i % NBITS;
            if (i < NBITS) exp_bit = (k < 8) ? w0[7-k] : p0;
            else           exp_bit = (k < 8) ? w1[7-k] : p1;
            n_cmp++;
            if (ser_out !== exp_bit || ser_out_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL b2b_bit%0d: out=%b valid=%b required %b/1",
                         i, ser_out, ser_out_valid, exp_bit);
            end
            if (i == NBITS - 1) begin
                @(posedge clock);
                #1 sif.data_valid = 1'b0;
            end
        end
        @(negedge clock);
        n_cmp++;
        if ({ser_out_valid, ser_busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL b2b_after: valid/busy=%b%b required 00", ser_out_valid, ser_busy);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] w;
        w = 8'hC5;
        @(negedge clock);
        sif.data_in = w;
        sif.data_valid = 1'b1;
        @(posedge clock);
        #1 sif.data_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_cmp++;
            if (ser_out !== w[7-i]) begin
                n_bad++;
                $display("FAIL midrst_bit%0d: out=%b required %b", i, ser_out, w[7-i]);
            end
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({ser_out, ser_out_valid, ser_busy, sif.data_ready} !== 4'b0001) begin
            n_bad++;
            $display("FAIL midrst_async: out/valid/busy/ready=%b%b%b%b required 0001",
                     ser_out, ser_out_valid, ser_busy, sif.data_ready);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (sif.data_ready !== 1'b1 || ser_out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_release: ready=%b valid=%b required 1/0",
                     sif.data_ready, ser_out_valid);
        end
        test_single(8'h3A, 1'b0);
    endtask

    task automatic test_detector_chain();
        logic [2:0] hist;
        int         pulses;
        int         pulse_at;
        hist = 3'b000;
        pulses = 0;
        pulse_at = -1;
        @(negedge clock);
        sif.data_in = 8'b0110_0000;
        sif.data_valid = 1'b1;
        @(posedge clock);
        #1 sif.data_valid = 1'b0;
        for (int i = 0; i < NBITS; i++) begin
            @(negedge clock);
            if (ser_out_valid === 1'b1) begin
                hist = {hist[1:0], ser_out};
                if (hist == 3'b110) begin
                    pulses++;
                    pulse_at = i;
                end
            end
        end
        n_cmp++;
        if (pulses !== 1 || pulse_at !== 3) begin
            n_bad++;
            $display("FAIL detector_pulse: count=%0d at=%0d required 1 at 3", pulses, pulse_at);
        end
        @(negedge clock);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_single(8'hC5, 1'b0);
        test_back_to_back(8'hC5, 1'b0, 8'h3A, 1'b0);
        test_reset_mid_word();
`ifdef SERIALIZER_PARITY_EN
        test_single(8'h07, 1'b1);
        test_back_to_back(8'h07, 1'b1, 8'hC5, 1'b0);
`else
        test_single(8'h07, 1'b1);
        test_back_to_back(8'hFF, 1'b0, 8'h01, 1'b1);
`endif
        test_detector_chain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
